clint_multi_hart: RTL and testbench
===================================

# clint_multi_hart

Parametrised core-local interruptor for multi-hart configurations: a shared 64-bit `mtime`, per-hart 64-bit `mtimecmp` and per-hart `msip` software-interrupt bits. It sits on the memory-mapped peripheral bus beside the harts and drives each hart's machine timer (MTIP) and software (MSIP) interrupt inputs. Unlike the single-hart draft, it adds a programmable timebase prescaler, a writable `mtime`, registered and acknowledged bus accesses, and registered interrupt outputs.

## Interface
- BASE_ADDR, 32'h2000_0000, base of the 0xC000-byte window
- N_HARTS, 4, number of harts, 1..16
- TICK_DIV, 1, `i_clk` cycles per `mtime` increment, ≥1
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-low reset
- i_wen  in  1  write request, single cycle
- i_ren  in  1  read request, single cycle
- i_addr  in  `XLEN`  byte address
- i_wrdata  in  `XLEN`  write data
- o_rddata  out  `XLEN`  read data, valid while `o_ack`=1
- o_ack  out  1  access completed, one cycle after the request
- o_msip  out  N_HARTS  software interrupt per hart
- o_mtip  out  N_HARTS  timer interrupt per hart

## Operation
- Map, offsets from BASE_ADDR, word-aligned only:
  - `msip[h]` at 0x0000+4h; only bit 0 is stored, and bits 31:1 read as 0.
  - `mtimecmp[h]` low word at 0x4000+8h, high word at +4.
  - `mtime` low word at 0xBFF8, high word at 0xBFFC.
- Unmapped addresses: writes are ignored; reads return 0; `o_ack` is still asserted. Unmapped covers misaligned addresses, hart index ≥ N_HARTS, and anything outside the window.
- Reset values: `mtime`=0; `mtimecmp[*]`=64'hFFFF_FFFF_FFFF_FFFF, so no spurious MTIP; `msip`=0; `o_msip`=0; `o_mtip`=0; `o_ack`=0; `o_rddata`=0; prescaler count=0.
- Prescaler: counts 0..TICK_DIV-1. A tick is generated on the wrap. `mtime` increments on each tick. With TICK_DIV=1 there is a tick every cycle.
- `mtime` wraps from 2^64-1 to 0.
- A write to either `mtime` half:
  - overrides the increment in that cycle, so the written value is held;
  - clears the prescaler count;
  - leaves the other half unchanged.
- Wrap-around does not change MTIP semantics. MTIP is an unsigned ≥ compare only.
- `o_mtip[h]` is registered `mtime >= mtimecmp[h]`, using the register values at the clock edge.
- `o_msip[h]` is `msip[h]` as a register.
- If `i_wen` and `i_ren` are asserted together, the write is performed and the read is dropped. `o_ack`=1 and `o_rddata`=0.
- Reset asserted mid-operation: the next edge loads all reset values and drops any pending ack.

## Timing
- Write: register updated at the request edge. `o_ack`=1 in cycle N+1.
- Read: `o_rddata` is captured at the request edge from pre-update register values. Both `o_rddata` and `o_ack` are valid in cycle N+1. Otherwise `o_rddata`=0.
- MTIP latency: 1 cycle after the `mtime`/`mtimecmp` edge that makes the compare true or false. Example: a `mtimecmp` write at edge N is seen on `o_mtip` after edge N+1.
- MSIP latency: `o_msip` changes at the write edge, visible in cycle N+1.
- Back-to-back requests every cycle are supported. There are no wait states and no outstanding-request limit.

## Structure
- Shared package `clint_pkg` holds:
  - offsets MSIP_OFF=0x0000, MTIMECMP_OFF=0x4000, MTIME_OFF=0xBFF8;
  - strides MSIP_STRIDE=4, MTIMECMP_STRIDE=8;
  - the reset constant MTIMECMP_RST.
- Sub-module `clint_prescaler` (params TICK_DIV; ports i_clk, i_rst, i_clr, o_tick). Counter width is $clog2(TICK_DIV), with TICK_DIV=1 degenerating to o_tick=1.
- Top level contains:
  - address decode yielding hart index and register select;
  - the register arrays;
  - per-hart compare via a generate loop.

## Test plan
- Reset with N_HARTS=4 and TICK_DIV=1, run 10 cycles. Required: `o_mtip`=0, `o_msip`=0, and a read of 0xBFF8 returns a small nonzero count with `o_ack` one cycle later.
- Write `mtimecmp[2]`=20 (low word, then high=0) with `mtime` near 0. Required: only `o_mtip[2]` rises, exactly one cycle after `mtime` reaches 20. Then write `mtimecmp[2]`=all-ones. Required: `o_mtip[2]` falls one cycle later.
- Write `msip[1]`=32'hFFFF_FFFF. Required: `o_msip`=4'b0010 and a read returns 1. Then write 0. Required: `o_msip`=0.
- With TICK_DIV=4, write `mtime` low=32'hFFFF_FFFE and high=0. Required: `mtime` holds for 4 cycles, then steps to 32'hFFFF_FFFF, then to high=1 and low=0.
- Read 0x0010 (hart 4, absent), 0x4002 (misaligned) and BASE-4. Required: `o_ack`=1, data 0, no register changes. Simultaneous `i_wen`/`i_ren` to `msip[0]`: write occurs and `o_rddata`=0.
- Assert `i_rst`=0 for one cycle mid-stream while `o_mtip`=4'hF. Required: on the next cycle all outputs are 0 and `mtimecmp` reads back all-ones.

Source files
------------

// File: rtl/clint_pkg.sv
// Shared constants, register-select encoding and address decode for the CLINT.
// Pure definitions, no timing of its own.
// Used by the top level and the prescaler.
package clint_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] MSIP_OFF        = 32'h0000_0000;
    localparam logic [XLEN-1:0] MTIMECMP_OFF    = 32'h0000_4000;
    localparam logic [XLEN-1:0] MTIME_OFF       = 32'h0000_BFF8;
    localparam int              MSIP_STRIDE     = 4;
    localparam int              MTIMECMP_STRIDE = 8;

    // All-ones compare value keeps MTIP low until software programs a deadline
    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    // Enough bits to name any of up to 16 harts
    localparam int HART_IDX_W = 4;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_MSIP,
        SEL_CMP_LO,
        SEL_CMP_HI,
        SEL_MTIME_LO,
        SEL_MTIME_HI
    } reg_sel_e;

    typedef struct packed {
        reg_sel_e                sel;
        logic [HART_IDX_W-1:0]   hart;
    } dec_t;

    // Decode a window-relative offset. An address below the base wraps to a
    // huge offset, and anything at or above the window end falls through
    // every range check, so both end up as SEL_NONE without a separate test.
    function automatic dec_t clint_decode(input logic [XLEN-1:0] off,
                                          input logic [XLEN-1:0] n_harts);
        dec_t            d;
        logic [XLEN-1:0] idx;
        d.sel  = SEL_NONE;
        d.hart = '0;
        idx    = '0;
        if (off[1:0] == 2'b00) begin
            if (off < MTIMECMP_OFF) begin
                idx = (off - MSIP_OFF) / XLEN'(MSIP_STRIDE);
                if (idx < n_harts) begin
                    d.sel  = SEL_MSIP;
                    d.hart = idx[HART_IDX_W-1:0];
                end
            end else if (off < MTIME_OFF) begin
                idx = (off - MTIMECMP_OFF) / XLEN'(MTIMECMP_STRIDE);
                if (idx < n_harts) begin
                    d.sel  = off[2] ? SEL_CMP_HI : SEL_CMP_LO;
                    d.hart = idx[HART_IDX_W-1:0];
                end
            end else if (off == MTIME_OFF) begin
                d.sel = SEL_MTIME_LO;
            end else if (off == MTIME_OFF + 32'd4) begin
                d.sel = SEL_MTIME_HI;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/clint_multi_hart_prescaler.sv
// Timebase prescaler: one o_tick pulse every TICK_DIV clocks (constant 1 when TICK_DIV=1).
// Tick is combinational from the counter; the count restarts on i_clr.
// No backpressure; free-running.
module clint_prescaler
    import clint_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    output logic o_tick
);

    if (TICK_DIV <= 1) begin : g_passthru
        // Every cycle is a tick; the clock and controls are not needed
        logic unused_in;
        assign unused_in = ^{i_clk, i_rst, i_clr};
        assign o_tick    = 1'b1;
    end else begin : g_count
        localparam int            CW   = $clog2(TICK_DIV);
        localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;

        assign o_tick = (cnt_q == LAST);

        // Count 0..TICK_DIV-1, wrapping on the tick or restarting on clear
        always_comb begin
            cnt_d = cnt_q + CW'(1);
            if (i_clr || o_tick) begin
                cnt_d = '0;
            end
        end

        // Counter register with synchronous active-low reset
        always_ff @(posedge i_clk) begin
            if (!i_rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

endmodule

// File: rtl/clint_multi_hart.sv
// Multi-hart CLINT: shared mtime, per-hart mtimecmp/msip, registered MTIP/MSIP outputs.
// Bus access acks one cycle after the request; MTIP lags its compare edge by one cycle.
// No wait states; a request may be issued every cycle.
module clint_multi_hart
    import clint_pkg::*;
#(
    parameter logic [XLEN-1:0] BASE_ADDR = 32'h2000_0000,
    parameter int              N_HARTS   = 4,
    parameter int              TICK_DIV  = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_wen,
    input  logic               i_ren,
    input  logic [XLEN-1:0]    i_addr,
    input  logic [XLEN-1:0]    i_wrdata,
    output logic [XLEN-1:0]    o_rddata,
    output logic               o_ack,
    output logic [N_HARTS-1:0] o_msip,
    output logic [N_HARTS-1:0] o_mtip
);

    localparam logic [XLEN-1:0] N_HARTS_L = XLEN'(N_HARTS);

    dec_t               dec;
    logic               tick;
    logic               mtime_wr;
    logic [XLEN-1:0]    rd_mux;

    logic [63:0]        mtime_q,    mtime_d;
    logic [63:0]        mtimecmp_q [N_HARTS];
    logic [63:0]        mtimecmp_d [N_HARTS];
    logic [N_HARTS-1:0] msip_q,     msip_d;
    logic [N_HARTS-1:0] mtip_q,     mtip_d;
    logic               ack_q,      ack_d;
    logic [XLEN-1:0]    rddata_q,   rddata_d;

    assign dec      = clint_decode(i_addr - BASE_ADDR, N_HARTS_L);
    assign mtime_wr = i_wen && ((dec.sel == SEL_MTIME_LO) || (dec.sel == SEL_MTIME_HI));

    // A write to mtime restarts the prescaler so the written value is held a full period
    clint_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (mtime_wr),
        .o_tick (tick)
    );

    // mtime: a software write to either half takes priority over the tick
    always_comb begin
        mtime_d = mtime_q;
        if (i_wen && (dec.sel == SEL_MTIME_LO)) begin
            mtime_d[31:0] = i_wrdata;
        end else if (i_wen && (dec.sel == SEL_MTIME_HI)) begin
            mtime_d[63:32] = i_wrdata;
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    // Per-hart msip/mtimecmp writes; only msip bit 0 is kept
    always_comb begin
        msip_d = msip_q;
        for (int h = 0; h < N_HARTS; h++) begin
            mtimecmp_d[h] = mtimecmp_q[h];
            if (i_wen && (dec.hart == HART_IDX_W'(h))) begin
                if (dec.sel == SEL_MSIP) begin
                    msip_d[h] = i_wrdata[0];
                end
                if (dec.sel == SEL_CMP_LO) begin
                    mtimecmp_d[h][31:0] = i_wrdata;
                end
                if (dec.sel == SEL_CMP_HI) begin
                    mtimecmp_d[h][63:32] = i_wrdata;
                end
            end
        end
    end

    // Read mux from pre-update register values; a concurrent write drops the read
    always_comb begin
        rd_mux = '0;
        for (int h = 0; h < N_HARTS; h++) begin
            if (dec.hart == HART_IDX_W'(h)) begin
                if (dec.sel == SEL_MSIP) begin
                    rd_mux = XLEN'(msip_q[h]);
                end
                if (dec.sel == SEL_CMP_LO) begin
                    rd_mux = mtimecmp_q[h][31:0];
                end
                if (dec.sel == SEL_CMP_HI) begin
                    rd_mux = mtimecmp_q[h][63:32];
                end
            end
        end
        if (dec.sel == SEL_MTIME_LO) begin
            rd_mux = mtime_q[31:0];
        end
        if (dec.sel == SEL_MTIME_HI) begin
            rd_mux = mtime_q[63:32];
        end
        rddata_d = (i_ren && !i_wen) ? rd_mux : '0;
        ack_d    = i_wen || i_ren;
    end

    // Unsigned compare per hart; the result is registered for a one-cycle lag
    for (genvar h = 0; h < N_HARTS; h++) begin : g_cmp
        assign mtip_d[h] = (mtime_q >= mtimecmp_q[h]);
    end

    // State registers with synchronous active-low reset; reset also kills a pending ack
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            mtime_q  <= '0;
            msip_q   <= '0;
            mtip_q   <= '0;
            ack_q    <= 1'b0;
            rddata_q <= '0;
            for (int h = 0; h < N_HARTS; h++) begin
                mtimecmp_q[h] <= MTIMECMP_RST;
            end
        end else begin
            mtime_q  <= mtime_d;
            msip_q   <= msip_d;
            mtip_q   <= mtip_d;
            ack_q    <= ack_d;
            rddata_q <= rddata_d;
            for (int h = 0; h < N_HARTS; h++) begin
                mtimecmp_q[h] <= mtimecmp_d[h];
            end
        end
    end

    assign o_msip   = msip_q;
    assign o_mtip   = mtip_q;
    assign o_ack    = ack_q;
    assign o_rddata = rddata_q;

endmodule

// File: tb/tb_clint_multi_hart.sv
// Directed bench for clint_multi_hart: one instance with TICK_DIV=1, one with TICK_DIV=4,
// both sharing clock, reset and bus inputs. Inputs change on the falling edge,
// outputs are sampled on the falling edge after the rising edge that produced them.
module tb_clint_multi_hart;

    localparam logic [31:0] BASE = 32'h2000_0000;

    logic        clk;
    logic        i_rst;
    logic        i_wen;
    logic        i_ren;
    logic [31:0] i_addr;
    logic [31:0] i_wrdata;

    logic [31:0] rd1, rd4;
    logic        ack1, ack4;
    logic [3:0]  msip1, mtip1, msip4, mtip4;

    int n_cmp  = 0;
    int n_fail = 0;

    clint_multi_hart #(.BASE_ADDR(BASE), .N_HARTS(4), .TICK_DIV(1)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_wen(i_wen), .i_ren(i_ren),
        .i_addr(i_addr), .i_wrdata(i_wrdata),
        .o_rddata(rd1), .o_ack(ack1), .o_msip(msip1), .o_mtip(mtip1)
    );

    clint_multi_hart #(.BASE_ADDR(BASE), .N_HARTS(4), .TICK_DIV(4)) dut4 (
        .i_clk(clk), .i_rst(i_rst), .i_wen(i_wen), .i_ren(i_ren),
        .i_addr(i_addr), .i_wrdata(i_wrdata),
        .o_rddata(rd4), .o_ack(ack4), .o_msip(msip4), .o_mtip(mtip4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called on a falling edge; returns on the falling edge of the ack cycle
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        i_wen    = 1'b1;
        i_addr   = addr;
        i_wrdata = data;
        @(negedge clk);
        i_wen    = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] d1,
                            output logic [31:0] d4, output logic a1);
        i_ren  = 1'b1;
        i_addr = addr;
        @(negedge clk);
        i_ren  = 1'b0;
        d1 = rd1;
        d4 = rd4;
        a1 = ack1;
    endtask

    task automatic test_reset();
        logic [31:0] d1, d4;
        logic        a1;
        repeat (2) @(negedge clk);
        n_cmp++; if ({mtip1, msip1, ack1, rd1} !== 42'd0) begin n_fail++;
            $display("FAIL rst_outputs: got mtip=%h msip=%h ack=%b rd=%h, want all 0", mtip1, msip1, ack1, rd1); end
        i_rst = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++; if ({mtip1, msip1} !== 8'd0) begin n_fail++;
            $display("FAIL rst_irq_idle: got mtip=%h msip=%h, want 0", mtip1, msip1); end
        n_cmp++; if (ack1 !== 1'b0) begin n_fail++;
            $display("FAIL rst_ack_idle: got %b want 0", ack1); end
        bus_read(BASE + 32'hBFF8, d1, d4, a1);
        n_cmp++; if (d1 !== 32'd10) begin n_fail++;
            $display("FAIL rst_mtime_count: got %0d want 10", d1); end
        n_cmp++; if (a1 !== 1'b1) begin n_fail++;
            $display("FAIL rst_read_ack: got %b want 1", a1); end
        @(negedge clk);
        n_cmp++; if ({ack1, rd1} !== 33'd0) begin n_fail++;
            $display("FAIL rst_ack_drop: got ack=%b rd=%h want 0/0", ack1, rd1); end
    endtask

    task automatic test_mtimecmp();
        logic [31:0] d1, d4;
        logic        a1;
        bus_write(BASE + 32'hBFF8, 32'd0);
        bus_write(BASE + 32'hBFFC, 32'd0);
        bus_write(BASE + 32'h4010, 32'd20);
        bus_write(BASE + 32'h4014, 32'd0);
        // mtime is 2 here and advances one per cycle
        n_cmp++; if (ack1 !== 1'b1) begin n_fail++;
            $display("FAIL cmp_write_ack: got %b want 1", ack1); end
        repeat (18) @(negedge clk);
        n_cmp++; if (mtip1 !== 4'b0000) begin n_fail++;
            $display("FAIL cmp_mtip_early: got %b want 0000", mtip1); end
        bus_read(BASE + 32'hBFF8, d1, d4, a1);
        n_cmp++; if (d1 !== 32'd20) begin n_fail++;
            $display("FAIL cmp_mtime_at_20: got %0d want 20", d1); end
        n_cmp++; if (mtip1 !== 4'b0100) begin n_fail++;
            $display("FAIL cmp_mtip_rise: got %b want 0100", mtip1); end
        bus_write(BASE + 32'h4010, 32'hFFFF_FFFF);
        n_cmp++; if (mtip1 !== 4'b0100) begin n_fail++;
            $display("FAIL cmp_mtip_hold: got %b want 0100", mtip1); end
        @(negedge clk);
        n_cmp++; if (mtip1 !== 4'b0000) begin n_fail++;
            $display("FAIL cmp_mtip_fall: got %b want 0000", mtip1); end
        bus_write(BASE + 32'h4014, 32'hFFFF_FFFF);
    endtask

    task automatic test_msip();
        logic [31:0] d1, d4;
        logic        a1;
        bus_write(BASE + 32'h4, 32'hFFFF_FFFF);
        n_cmp++; if (msip1 !== 4'b0010 || msip4 !== 4'b0010) begin n_fail++;
            $display("FAIL msip_set: got %b/%b want 0010", msip1, msip4); end
        n_cmp++; if (ack1 !== 1'b1) begin n_fail++;
            $display("FAIL msip_ack: got %b want 1", ack1); end
        bus_read(BASE + 32'h4, d1, d4, a1);
        n_cmp++; if (d1 !== 32'd1) begin n_fail++;
            $display("FAIL msip_readback: got %h want 00000001", d1); end
        bus_write(BASE + 32'h4, 32'd0);
        n_cmp++; if (msip1 !== 4'b0000) begin n_fail++;
            $display("FAIL msip_clear: got %b want 0000", msip1); end
    endtask

    task automatic test_prescaler();
        logic [31:0] d1, d4, exp;
        logic        a1;
        bus_write(BASE + 32'hBFF8, 32'hFFFF_FFFE);
        bus_write(BASE + 32'hBFFC, 32'd0);
        for (int i = 1; i <= 8; i++) begin
            exp = (i <= 4) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF;
            bus_read(BASE + 32'hBFF8, d1, d4, a1);
            n_cmp++; if (d4 !== exp) begin n_fail++;
                $display("FAIL div4_mtime_lo[%0d]: got %h want %h", i, d4, exp); end
        end
        bus_read(BASE + 32'hBFFC, d1, d4, a1);
        n_cmp++; if (d4 !== 32'd1) begin n_fail++;
            $display("FAIL div4_mtime_hi_carry: got %h want 00000001", d4); end
        bus_read(BASE + 32'hBFF8, d1, d4, a1);
        n_cmp++; if (d4 !== 32'd0) begin n_fail++;
            $display("FAIL div4_mtime_lo_wrap: got %h want 00000000", d4); end
    endtask

    task automatic test_unmapped();
        logic [31:0] d1, d4;
        logic        a1;
        logic [31:0] bad [5];
        bad[0] = BASE + 32'h10;
        bad[1] = BASE + 32'h4002;
        bad[2] = BASE - 32'h4;
        bad[3] = BASE + 32'h4020;
        bad[4] = BASE + 32'hC000;
        for (int i = 0; i < 5; i++) bus_write(bad[i], 32'd1);
        for (int i = 0; i < 5; i++) begin
            bus_read(bad[i], d1, d4, a1);
            n_cmp++; if (d1 !== 32'd0 || a1 !== 1'b1) begin n_fail++;
                $display("FAIL unmapped_read %h: got data=%h ack=%b want 0/1", bad[i], d1, a1); end
        end
        n_cmp++; if (msip1 !== 4'b0000) begin n_fail++;
            $display("FAIL unmapped_msip: got %b want 0000", msip1); end
        bus_read(BASE + 32'h4000, d1, d4, a1);
        n_cmp++; if (d1 !== 32'hFFFF_FFFF) begin n_fail++;
            $display("FAIL unmapped_cmp0_lo: got %h want ffffffff", d1); end
        bus_read(BASE + 32'h4004, d1, d4, a1);
        n_cmp++; if (d1 !== 32'hFFFF_FFFF) begin n_fail++;
            $display("FAIL unmapped_cmp0_hi: got %h want ffffffff", d1); end
    endtask

    task automatic test_wr_rd_collision();
        bus_write(BASE, 32'd1);
        n_cmp++; if (msip1 !== 4'b0001) begin n_fail++;
            $display("FAIL coll_pre_set: got %b want 0001", msip1); end
        i_wen = 1'b1; i_ren = 1'b1; i_addr = BASE; i_wrdata = 32'd0;
        @(negedge clk);
        i_wen = 1'b0; i_ren = 1'b0;
        n_cmp++; if (msip1 !== 4'b0000) begin n_fail++;
            $display("FAIL coll_write_done: got %b want 0000", msip1); end
        n_cmp++; if (ack1 !== 1'b1 || rd1 !== 32'd0) begin n_fail++;
            $display("FAIL coll_read_dropped: got ack=%b rd=%h want 1/0", ack1, rd1); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d1, d4;
        logic        a1;
        for (int h = 0; h < 4; h++) begin
            bus_write(BASE + 32'h4000 + 32'(8 * h), 32'd0);
            bus_write(BASE + 32'h4004 + 32'(8 * h), 32'd0);
        end
        bus_write(BASE + 32'h8, 32'd1);
        n_cmp++; if (mtip1 !== 4'hF || msip1 !== 4'b0100) begin n_fail++;
            $display("FAIL mid_pre_state: got mtip=%h msip=%b want f/0100", mtip1, msip1); end
        i_rst = 1'b0; i_ren = 1'b1; i_addr = BASE + 32'hBFF8;
        @(negedge clk);
        i_rst = 1'b1; i_ren = 1'b0;
        n_cmp++; if ({mtip1, msip1, ack1, rd1} !== 42'd0) begin n_fail++;
            $display("FAIL mid_rst_outputs: got mtip=%h msip=%h ack=%b rd=%h want 0", mtip1, msip1, ack1, rd1); end
        n_cmp++; if ({mtip4, msip4, ack4} !== 9'd0) begin n_fail++;
            $display("FAIL mid_rst_div4: got mtip=%h msip=%h ack=%b want 0", mtip4, msip4, ack4); end
        for (int h = 0; h < 4; h++) begin
            bus_read(BASE + 32'h4000 + 32'(8 * h), d1, d4, a1);
            n_cmp++; if (d1 !== 32'hFFFF_FFFF) begin n_fail++;
                $display("FAIL mid_cmp%0d_lo: got %h want ffffffff", h, d1); end
            bus_read(BASE + 32'h4004 + 32'(8 * h), d1, d4, a1);
            n_cmp++; if (d1 !== 32'hFFFF_FFFF) begin n_fail++;
                $display("FAIL mid_cmp%0d_hi: got %h want ffffffff", h, d1); end
        end
        n_cmp++; if (mtip1 !== 4'h0) begin n_fail++;
            $display("FAIL mid_mtip_stays_low: got %h want 0", mtip1); end
    endtask

    initial begin
        i_rst    = 1'b0;
        i_wen    = 1'b0;
        i_ren    = 1'b0;
        i_addr   = '0;
        i_wrdata = '0;
        test_reset();
        test_mtimecmp();
        test_msip();
        test_prescaler();
        test_unmapped();
        test_wr_rd_collision();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: summary not reached within 200000 time units");
        $fatal(1);
    end

endmodule
